// File: rtl/regfile_sb.sv
// Register file with two write-back ports, bypassed combinational reads and a RAW scoreboard.
// Reads and rbusy are same-cycle, with no backpressure. ready gates every input until the post-reset clear has zeroed the array.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic                     flush,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     we_a,
  input  logic [ADDR_W-1:0]        waddr_a,
  input  logic [DATA_W-1:0]        wdata_a,
  input  logic                     we_b,
  input  logic [ADDR_W-1:0]        waddr_b,
  input  logic [DATA_W-1:0]        wdata_b,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_idx, clr_idx_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    sb, sb_nxt;
  logic [ADDR_W:0]     cnt_nxt;
  logic                wr_a, wr_b, iss_en, flush_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    case (state)
      S_CLEAR: begin
        clr_idx_nxt = clr_idx + ADDR_W'(1);
        if (clr_idx == ADDR_W'(DEPTH - 1)) state_nxt = S_RUN;
      end
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_CLEAR;
    endcase
  end

  assign ready = (state == S_RUN);

  // Register 0 is filtered out here so neither the array nor the scoreboard ever sees it.
  assign wr_a     = ready && we_a && !(ZR && (waddr_a == '0));
  assign wr_b     = ready && we_b && !(ZR && (waddr_b == '0));
  assign iss_en   = ready && iss_valid && !(ZR && (iss_addr == '0));
  assign flush_en = ready && flush;

  // Port B is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[clr_idx] <= '0;
    end else begin
      if (wr_a) mem[waddr_a] <= wdata_a;
      if (wr_b) mem[waddr_b] <= wdata_b;
    end
  end

  always_comb begin
    sb_nxt = sb;
    if (wr_a) sb_nxt[waddr_a] = 1'b0;
    if (wr_b) sb_nxt[waddr_b] = 1'b0;
    if (iss_en) sb_nxt[iss_addr] = 1'b1;
    if (flush_en) sb_nxt = '0;
    cnt_nxt = '0;
    for (int r = 0; r < DEPTH; r++) begin
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(sb_nxt[r]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb       <= '0;
      busy_cnt <= '0;
    end else begin
      sb       <= sb_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  // A same-cycle write-back both supplies the data and retires the hazard.
  always_comb begin
    logic [ADDR_W-1:0] a;
    a     = '0;
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a = raddr[i*ADDR_W +: ADDR_W];
      if (rst && ready && re[i] && !(ZR && (a == '0))) begin
        if (wr_b && (waddr_b == a))      rdata[i*DATA_W +: DATA_W] = wdata_b;
        else if (wr_a && (waddr_a == a)) rdata[i*DATA_W +: DATA_W] = wdata_a;
        else                             rdata[i*DATA_W +: DATA_W] = mem[a];
        rbusy[i] = sb[a] && !(wr_a && (waddr_a == a)) && !(wr_b && (waddr_b == a));
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized and directed bench for regfile_sb against an array/counter reference model.
module tb_regfile_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 2**ADDR_W;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     ready;
  logic                     flush;
  logic                     iss_valid;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     we_a;
  logic [ADDR_W-1:0]        waddr_a;
  logic [DATA_W-1:0]        wdata_a;
  logic                     we_b;
  logic [ADDR_W-1:0]        waddr_b;
  logic [DATA_W-1:0]        wdata_b;
  logic [NUM_RD-1:0]        re;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic [ADDR_W:0]          busy_cnt;

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .ready(ready), .flush(flush),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] mem_m [DEPTH];
  bit                sb_m  [DEPTH];
  int                since_rel;
  bit                ready_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int busy_m();
    int n = 0;
    for (int r = 0; r < DEPTH; r++) n += int'(sb_m[r]);
    return n;
  endfunction

  function automatic logic [DATA_W-1:0] exp_rdata(input int i);
    int a = int'(raddr[i*ADDR_W +: ADDR_W]);
    if (!ready_m || !re[i] || a == 0) return '0;
    if (we_b && int'(waddr_b) == a) return wdata_b;
    if (we_a && int'(waddr_a) == a) return wdata_a;
    return mem_m[a];
  endfunction

  function automatic bit exp_rbusy(input int i);
    int a = int'(raddr[i*ADDR_W +: ADDR_W]);
    if (!ready_m || !re[i] || a == 0) return 1'b0;
    if ((we_b && int'(waddr_b) == a) || (we_a && int'(waddr_a) == a)) return 1'b0;
    return sb_m[a];
  endfunction

  task automatic model_reset();
    since_rel = 0;
    ready_m   = 1'b0;
    for (int r = 0; r < DEPTH; r++) sb_m[r] = 1'b0;
  endtask

  task automatic model_edge();
    if (!ready_m) begin
      since_rel++;
      if (since_rel >= DEPTH) begin
        ready_m = 1'b1;
        for (int r = 0; r < DEPTH; r++) mem_m[r] = '0;
      end
    end else begin
      if (we_a && waddr_a != 0) mem_m[waddr_a] = wdata_a;
      if (we_b && waddr_b != 0) mem_m[waddr_b] = wdata_b;
      if (we_a) sb_m[waddr_a] = 1'b0;
      if (we_b) sb_m[waddr_b] = 1'b0;
      if (iss_valid && iss_addr != 0) sb_m[iss_addr] = 1'b1;
      if (flush) for (int r = 0; r < DEPTH; r++) sb_m[r] = 1'b0;
      sb_m[0] = 1'b0;
    end
  endtask

  // Called with inputs already driven just after a rising edge.
  task automatic cyc(input string tag);
    #1;
    for (int i = 0; i < NUM_RD; i++) begin
      chk({tag, "_rdata"}, 64'(rdata[i*DATA_W +: DATA_W]), 64'(exp_rdata(i)));
      chk({tag, "_rbusy"}, 64'(rbusy[i]), 64'(exp_rbusy(i)));
    end
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, "_ready"}, 64'(ready), 64'(ready_m));
    chk({tag, "_busy_cnt"}, 64'(busy_cnt), 64'(busy_m()));
  endtask

  task automatic idle();
    flush = 1'b0; iss_valid = 1'b0; we_a = 1'b0; we_b = 1'b0; re = '0;
  endtask

  task automatic rd(input int p, input int a);
    raddr[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
    re[p] = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    iss_addr = '0; waddr_a = '0; waddr_b = '0; wdata_a = '0; wdata_b = '0; raddr = '0;
    idle();
    model_reset();
    re = '1;
    #2;
    chk("rst_ready", 64'(ready), 64'h0);
    chk("rst_busy_cnt", 64'(busy_cnt), 64'h0);
    chk("rst_rdata", 64'(rdata[DATA_W-1:0]), 64'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle();

    // Clear sequence: ready must rise after exactly DEPTH edges.
    for (int k = 0; k < DEPTH; k++) begin
      if (k == DEPTH - 1) chk("clear_ready_low", 64'(ready), 64'h0);
      cyc("clear");
    end
    chk("clear_ready_high", 64'(ready), 64'h1);
    for (int a = 0; a < DEPTH; a++) begin
      rd(0, a); rd(1, DEPTH - 1 - a);
      cyc("clear_read");
    end

    // Bypass then stored value.
    idle(); we_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'hDEADBEEF; rd(0, 3);
    #1 chk("bypass_a", 64'(rdata[DATA_W-1:0]), 64'hDEADBEEF);
    cyc("bypass");
    idle(); rd(0, 3);
    #1 chk("stored_3", 64'(rdata[DATA_W-1:0]), 64'hDEADBEEF);
    cyc("stored");

    // Same-address collision: port B wins; register 0 stays zero.
    idle(); we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h11; we_b = 1'b1; waddr_b = 5'd7; wdata_b = 32'h22;
    cyc("collide");
    idle(); rd(1, 7); we_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'hFFFF_FFFF; rd(0, 0);
    #1 chk("collide_b_wins", 64'(rdata[DATA_W +: DATA_W]), 64'h22);
    chk("zero_bypass", 64'(rdata[DATA_W-1:0]), 64'h0);
    cyc("zero_wr");
    idle(); rd(0, 0);
    #1 chk("zero_read", 64'(rdata[DATA_W-1:0]), 64'h0);
    cyc("zero_rd");

    // Issue / write-back on reg 5.
    idle(); iss_valid = 1'b1; iss_addr = 5'd5;
    cyc("iss5");
    idle(); rd(0, 5);
    #1 chk("iss5_rbusy", 64'(rbusy[0]), 64'h1);
    chk("iss5_cnt", 64'(busy_cnt), 64'h1);
    cyc("iss5_hold");
    idle(); rd(0, 5); we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'h55;
    #1 chk("wb5_rbusy", 64'(rbusy[0]), 64'h0);
    cyc("wb5");
    chk("wb5_cnt", 64'(busy_cnt), 64'h0);

    // Issue beats same-cycle write-back; flush clears.
    idle(); iss_valid = 1'b1; iss_addr = 5'd9; we_b = 1'b1; waddr_b = 5'd9; wdata_b = 32'h99;
    cyc("iss9_wb9");
    chk("iss9_cnt", 64'(busy_cnt), 64'h1);
    idle(); flush = 1'b1;
    cyc("flush");
    chk("flush_cnt", 64'(busy_cnt), 64'h0);

    // Randomized traffic on a narrow address window to force collisions.
    for (int k = 0; k < 400; k++) begin
      idle();
      we_a      = 1'($urandom_range(0, 1));
      we_b      = 1'($urandom_range(0, 3) == 0);
      iss_valid = 1'($urandom_range(0, 1));
      flush     = 1'($urandom_range(0, 31) == 0);
      waddr_a   = ADDR_W'($urandom_range(0, 9));
      waddr_b   = ADDR_W'($urandom_range(0, 9));
      iss_addr  = ADDR_W'($urandom_range(0, 9));
      wdata_a   = $urandom;
      wdata_b   = $urandom;
      re        = NUM_RD'($urandom);
      raddr     = {ADDR_W'($urandom_range(0, 9)), ADDR_W'($urandom_range(0, 9))};
      cyc("rand");
    end

    // Mid-run reset with three busy registers.
    idle(); flush = 1'b1;
    cyc("pre_flush");
    for (int r = 1; r <= 3; r++) begin
      idle(); iss_valid = 1'b1; iss_addr = ADDR_W'(r + 10);
      cyc("iss3");
    end
    idle();
    chk("iss3_cnt", 64'(busy_cnt), 64'h3);
    rst = 1'b0;
    #1;
    chk("midrst_ready", 64'(ready), 64'h0);
    chk("midrst_cnt", 64'(busy_cnt), 64'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < DEPTH; k++) cyc("reclear");
    chk("reclear_ready", 64'(ready), 64'h1);
    for (int a = 0; a < DEPTH; a++) begin
      idle(); rd(0, a); rd(1, a);
      #1 chk("reclear_zero", 64'(rdata[DATA_W-1:0]), 64'h0);
      cyc("reclear_read");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
